aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Sequencer for the iterative AES-128 core. Accepts one block request via valid/ready,
//  drives the core's accept, KS_Select and rndNo controls through load, 10 rounds and the
//  final-round drain, then holds result-valid until the consumer takes it.
//  Sits between the host/testbench interface and the AES core; one block in flight.
// PARAMETERS
//  NR         10  number of cipher rounds (AES-128)
//  CPR        4   clock cycles per round (core loop pipeline depth)
//  FINAL_LAT  2   cycles from the last round-phase to cipher_text valid at the core output
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rstn        in   1  synchronous reset, active-low
//  start       in   1  request: block + key presented on core inputs this cycle
//  start_ready out  1  controller can take a request this cycle
//  accept      out  1  to core: capture plain_text/cipher_key
//  KS_Select   out  1  to core: load key schedule from cipher_key
//  rndNo       out  4  to core: current round number
//  busy        out  1  block in flight (LOAD..FINAL)
//  out_valid   out  1  cipher_text at core output is valid
//  out_ready   in   1  consumer takes result when out_valid & out_ready
//  abort       in   1  (AES_CTRL_ABORT_EN only) cancel block in flight
// BEHAVIOUR
//  Reset (rstn=0 at edge): state=IDLE, accept=0, KS_Select=0, rndNo=0, busy=0, out_valid=0,
//   phase=0; applies mid-operation, block discarded, no out_valid ever issued for it.
//  start_ready = (state==IDLE) | (state==DONE & out_ready). Handshake = start & start_ready.
//  start while start_ready=0 is ignored (not queued).
//  States: IDLE -> LOAD -> ROUND -> FINAL -> DONE -> IDLE|LOAD.
//   IDLE : all outputs 0. Handshake -> LOAD.
//   LOAD : 1 cycle; accept=1, KS_Select=1, rndNo=0, busy=1. -> ROUND, phase=0.
//   ROUND: accept=0, KS_Select=0, busy=1; phase counts 0..CPR-1; on phase==CPR-1 phase
//          wraps to 0 and rndNo increments; when rndNo reaches NR -> FINAL.
//          rndNo stays constant for exactly CPR cycles per value 0..NR-1.
//   FINAL: rndNo=NR held, counter runs 0..FINAL_LAT-1, then -> DONE.
//   DONE : out_valid=1, busy=0, rndNo=NR held; out_valid stays high until out_ready.
//          out_ready & !start -> IDLE (rndNo->0). out_ready & start -> LOAD same edge
//          (back-to-back, zero bubble). !out_ready: hold, start ignored.
//  Latency: handshake edge to out_valid = 1 + NR*CPR + FINAL_LAT cycles (43 by default).
//  rndNo is 4 bits; NR must be <=15 (elaborate-time check). Phase counter width
//   = clog2(max(CPR,FINAL_LAT)); counters never wrap past their limit.
//  All outputs registered; no combinational path from start/out_ready to core controls
//   except start_ready (combinational from state and out_ready).
// CONFIGURATION
//  AES_CTRL_ABORT_EN defined: abort=1 at an edge in LOAD/ROUND/FINAL -> IDLE, rndNo=0,
//   no out_valid; abort in IDLE/DONE ignored; abort beats start in same cycle.
//  Undefined: abort port absent; block always runs to DONE.
// STRUCTURE
//  Shared include aes_defs.vh: state encodings (IDLE..DONE, 3-bit), AES128_NR=10,
//   AES_RNDNO_W=4, default CPR/FINAL_LAT constants used by core and controller.
//  One sub-module: aes_phase_counter (load/enable/terminal-count, parameterised width),
//   instanced once, reused for ROUND phase and FINAL wait.
// TESTING
//  Reset: rstn=0 2 cycles with start=1 -> all outputs 0, start_ready=1 after release.
//  Single block with core: pt 00112233445566778899aabbccddeeff, key 000102..0e0f, start 1
//   cycle -> accept/KS_Select high 1 cycle, rndNo 0..9 each 4 cycles, out_valid at cycle 43,
//   cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
//  Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid/rndNo=10 held, start
//   pulses ignored, start_ready=0; out_ready=1 -> IDLE next edge.
//  Back-to-back: start held high, out_ready=1 -> LOAD on the edge DONE exits, results
//   every 44 cycles, second vector correct.
//  Reset mid-ROUND (rndNo=5): rstn=0 1 cycle -> IDLE, no out_valid; next block correct.
//  AES_CTRL_ABORT_EN: abort at rndNo=3 -> IDLE next edge, no out_valid; abort+start in
//   IDLE -> LOAD (abort ignored in IDLE).

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared state encoding and AES-128 timing defaults for the round sequencer and core.
package aes_round_ctrl_pkg;

  localparam int AES128_NR         = 10;
  localparam int AES_RNDNO_W       = 4;
  localparam int AES_DEF_CPR       = 4;
  localparam int AES_DEF_FINAL_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // Width able to count 0..max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_phase_counter.sv
// Phase counter: clears to 0, counts while enabled, flags and wraps at a runtime limit.
// Single-cycle terminal count, no backpressure.
module aes_round_ctrl_phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: out_valid 1+NR*CPR+FINAL_LAT cycles after start handshake, held until out_ready.
// `define AES_CTRL_ABORT_EN adds an abort input that cancels the block in flight.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int CPR       = AES_DEF_CPR,
  parameter int FINAL_LAT = AES_DEF_FINAL_LAT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  output logic                   start_ready,
  output logic                   accept,
  output logic                   KS_Select,
  output logic [AES_RNDNO_W-1:0] rndNo,
  output logic                   busy,
  output logic                   out_valid,
`ifdef AES_CTRL_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   out_ready
);

  localparam int PW = cnt_width(CPR, FINAL_LAT);
  localparam logic [PW-1:0]          ROUND_LAST = PW'(CPR - 1);
  localparam logic [PW-1:0]          FINAL_LAST = PW'(FINAL_LAT - 1);
  localparam logic [AES_RNDNO_W-1:0] RND_LAST   = AES_RNDNO_W'(NR - 1);

  if (NR < 1 || NR > 15) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be in 1..15 to fit rndNo");
  end
  if (CPR < 1 || FINAL_LAT < 1) begin : g_bad_lat
    $error("aes_round_ctrl: CPR and FINAL_LAT must be at least 1");
  end

  ctrl_state_e            state_q, state_d;
  logic                   accept_q, accept_d;
  logic                   ks_select_q, ks_select_d;
  logic [AES_RNDNO_W-1:0] rnd_no_q, rnd_no_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;

  logic          abort_req;
  logic          handshake;
  logic          phase_run;
  logic          phase_tc;
  logic [PW-1:0] phase_limit;

`ifdef AES_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign start_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign handshake   = start & start_ready;

  // One counter serves both the per-round phase and the final drain wait.
  assign phase_run   = (state_q == ST_ROUND) | (state_q == ST_FINAL);
  assign phase_limit = (state_q == ST_FINAL) ? FINAL_LAST : ROUND_LAST;

  aes_round_ctrl_phase_counter #(.W(PW)) u_phase (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (~phase_run),
    .en    (phase_run),
    .limit (phase_limit),
    .tc    (phase_tc)
  );

  always_comb begin
    state_d     = state_q;
    rnd_no_d    = rnd_no_q;
    accept_d    = 1'b0;
    ks_select_d = 1'b0;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE:  if (handshake) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ROUND;
      ST_ROUND: begin
        if (phase_tc) begin
          rnd_no_d = rnd_no_q + 1'b1;
          if (rnd_no_q == RND_LAST) state_d = ST_FINAL;
        end
      end
      ST_FINAL: if (phase_tc) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = start ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort_req && (state_q == ST_LOAD || state_q == ST_ROUND || state_q == ST_FINAL)) begin
      state_d = ST_IDLE;
    end

    // Outputs follow the state being entered so they are registered alongside it.
    case (state_d)
      ST_LOAD: begin
        accept_d    = 1'b1;
        ks_select_d = 1'b1;
        busy_d      = 1'b1;
        rnd_no_d    = '0;
      end
      ST_ROUND, ST_FINAL: busy_d = 1'b1;
      ST_DONE:            out_valid_d = 1'b1;
      default:            rnd_no_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      accept_q    <= 1'b0;
      ks_select_q <= 1'b0;
      rnd_no_q    <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      accept_q    <= accept_d;
      ks_select_q <= ks_select_d;
      rnd_no_q    <= rnd_no_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign accept    = accept_q;
  assign KS_Select = ks_select_q;
  assign rndNo     = rnd_no_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: reset/startup vector table, timing corner sequences, random run vs age model.
module tb_aes_round_ctrl;

  localparam int M_NR  = 10;
  localparam int M_CPR = 4;
  localparam int M_FL  = 2;
  localparam int LAT   = 1 + M_NR * M_CPR + M_FL;
`ifdef AES_CTRL_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, start, out_ready;
  logic       start_ready, accept, KS_Select, busy, out_valid;
  logic [3:0] rndNo;
`ifdef AES_CTRL_ABORT_EN
  logic       abort;
`endif

  aes_round_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .start_ready (start_ready),
    .accept      (accept),
    .KS_Select   (KS_Select),
    .rndNo       (rndNo),
    .busy        (busy),
`ifdef AES_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  // Cycles since the accepted handshake; -1 when no block is in flight.
  int age        = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {accept, KS_Select, rndNo, busy, out_valid, start_ready};
  endfunction

  function automatic logic [8:0] exp_vec(input bit o);
    int  rnd;
    bit  acc, bsy, ov, sr;
    acc = (age == 0);
    bsy = (age >= 0) && (age < LAT);
    ov  = (age == LAT);
    sr  = (age < 0) || (ov && o);
    if (age <= 0)                rnd = 0;
    else if (age <= M_NR * M_CPR) rnd = (age - 1) / M_CPR;
    else                         rnd = M_NR;
    return {acc, acc, 4'(rnd), bsy, ov, sr};
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit o, input bit a);
    if (!r)                 age = -1;
    else if (age < 0)       begin if (s) age = 0; end
    else if (age < LAT)     age = (ABORT_ON && a) ? -1 : age + 1;
    else if (o)             age = s ? 0 : -1;
  endtask

  task automatic tick(input bit r, input bit s, input bit o, input bit a);
    rstn = r; start = s; out_ready = o;
`ifdef AES_CTRL_ABORT_EN
    abort = a;
`endif
    if (r) begin
      #1;
      chk("start_ready_pre", {31'd0, start_ready}, {31'd0, exp_vec(o)[0]});
    end
    @(posedge clk);
    model_edge(r, s, o, a);
    cyc++;
    @(negedge clk);
    chk("model", {23'd0, dut_vec()}, {23'd0, exp_vec(o)});
  endtask

  typedef struct {
    bit r, s, o;
    bit acc, ks;
    logic [3:0] rnd;
    bit bsy, ov, srdy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cyc, seen, n;
    int ov_t[$];
    bit prev_ov;

    rstn = 1'b0; start = 1'b0; out_ready = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort = 1'b0;
`endif

    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};

    hs_cyc = 0;
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].o, 1'b0);
      if (i == 3) hs_cyc = cyc;
      chk($sformatf("tbl%0d", i), {23'd0, dut_vec()},
          {23'd0, tbl[i].acc, tbl[i].ks, tbl[i].rnd, tbl[i].bsy, tbl[i].ov, tbl[i].srdy});
    end

    // Run the first block to completion and measure handshake-to-valid latency.
    n = 0;
    while (!out_valid && n < 100) begin tick(1, 0, 0, 0); n++; end
    chk("latency", cyc - hs_cyc, 43);

    // Backpressure: result and round number held, starts ignored.
    for (int i = 0; i < 10; i++) begin
      tick(1, i[0], 0, 0);
      chk("bp_hold", {26'd0, out_valid, rndNo, start_ready}, {26'd0, 1'b1, 4'd10, 1'b0});
    end
    start = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_srdy_done", {31'd0, start_ready}, 32'd1);
    tick(1, 0, 1, 0);
    chk("bp_release", {26'd0, out_valid, rndNo, busy}, 32'd0);

    // Back-to-back blocks with start held high.
    tick(1, 1, 1, 0);
    prev_ov = 1'b0;
    n = 0;
    while (ov_t.size() < 3 && n < 200) begin
      tick(1, 1, 1, 0);
      n++;
      if (prev_ov) chk("b2b_load", {31'd0, accept}, 32'd1);
      if (out_valid) ov_t.push_back(cyc);
      prev_ov = out_valid;
    end
    if (ov_t.size() < 3) begin
      chk("b2b_timeout", ov_t.size(), 3);
    end else begin
      chk("b2b_gap1", ov_t[1] - ov_t[0], 44);
      chk("b2b_gap2", ov_t[2] - ov_t[1], 44);
    end
    for (int i = 0; i < 50; i++) tick(1, 0, 1, 0);
    chk("b2b_drained", {31'd0, start_ready}, 32'd1);

    // Reset in the middle of round 5 discards the block.
    tick(1, 1, 1, 0);
    n = 0;
    while (rndNo != 4'd5 && n < 60) begin tick(1, 0, 1, 0); n++; end
    chk("mid_rnd5", {28'd0, rndNo}, 32'd5);
    tick(0, 0, 1, 0);
    chk("mid_reset", {23'd0, dut_vec()}, 32'h001);
    seen = 0;
    for (int i = 0; i < 50; i++) begin tick(1, 0, 1, 0); if (out_valid) seen++; end
    chk("mid_no_ovld", seen, 0);
    tick(1, 1, 0, 0);
    hs_cyc = cyc;
    n = 0;
    while (!out_valid && n < 100) begin tick(1, 0, 0, 0); n++; end
    chk("mid_next_lat", cyc - hs_cyc, 43);
    tick(1, 0, 1, 0);

`ifdef AES_CTRL_ABORT_EN
    tick(1, 1, 1, 0);
    n = 0;
    while (rndNo != 4'd3 && n < 60) begin tick(1, 0, 1, 0); n++; end
    tick(1, 0, 1, 1);
    chk("abort_idle", {23'd0, dut_vec()}, 32'h001);
    seen = 0;
    for (int i = 0; i < 50; i++) begin tick(1, 0, 1, 0); if (out_valid) seen++; end
    chk("abort_no_ovld", seen, 0);
    tick(1, 1, 1, 1);
    chk("abort_idle_ignored", {30'd0, accept, busy}, 32'd3);
    for (int i = 0; i < 50; i++) tick(1, 0, 1, 0);
`endif

    // Random traffic: bursts of light/heavy backpressure, rare resets and aborts.
    for (int blk = 0; blk < 20; blk++) begin
      int ordy_pct, start_pct;
      ordy_pct  = $urandom_range(10, 100);
      start_pct = $urandom_range(5, 90);
      for (int i = 0; i < 200; i++) begin
        tick($urandom_range(0, 299) != 0,
             $urandom_range(0, 99) < start_pct,
             $urandom_range(0, 99) < ordy_pct,
             $urandom_range(0, 79) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
